tt_host_link: RTL

- Pin-level responder that lets the external host (the cocotb bench, or a host MCU on silicon) read and write the uP0628 internal memory through the Tiny Tapeout pins.
- It is the device end of the host-to-chip pin protocol. The host is the initiator: it drives ui_in and uio_in. This block decodes requests, runs the memory port, and answers with an ack pin and read data on uio_out.
- It sits between the tt_um_maxluppe_uP0628_24 top-level pins and the processor memory arbiter.

---
 rtl/tt_host_link.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/tt_host_link.sv
// Device end of the host-to-chip pin protocol: decodes four-phase host requests and runs the memory port.
// Optional macro HOSTLINK_SYNC_EN inserts a 2-flop synchronizer on the req pin for an asynchronous host.
module tt_host_link #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [7:0]        ui_in,
  input  logic [7:0]        uio_in,
  output logic              ack,
  output logic              busy,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    RDWAIT = 2'd2,
    ACK    = 2'd3
  } state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b10;
  localparam logic [1:0] OP_RD   = 2'b11;

  state_t state_q, state_d;

  logic              req_s;
  logic [1:0]        op_q, op_d;
  logic [7:0]        data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        uio_out_q, uio_out_d;
  logic [7:0]        uio_oe_q, uio_oe_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic              accept;

  logic unused_ui;
  assign unused_ui = ^ui_in[4:0];

`ifdef HOSTLINK_SYNC_EN
  logic req_meta_q, req_meta_d;
  logic req_sync_q, req_sync_d;

  always_comb begin
    req_meta_d = ui_in[7];
    req_sync_d = req_meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_meta_q <= 1'b0;
      req_sync_q <= 1'b0;
    end else begin
      req_meta_q <= req_meta_d;
      req_sync_q <= req_sync_d;
    end
  end

  assign req_s = req_sync_q;
`else
  assign req_s = ui_in[7];
`endif

  assign accept = (state_q == IDLE) && req_s && ena;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = (op_q == OP_RD) ? RDWAIT : ACK;
      RDWAIT:  state_d = ACK;
      ACK:     if (!req_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state so they line up with the state they belong to.
  always_comb begin
    op_d      = op_q;
    data_d    = data_q;
    addr_d    = addr_q;
    uio_out_d = uio_out_q;

    if (accept) begin
      op_d   = ui_in[6:5];
      data_d = uio_in;
    end

    if ((state_q == EXEC) && (op_q == OP_SET)) begin
      addr_d = data_q[ADDR_W-1:0];
    end

    if (state_q == RDWAIT) begin
      uio_out_d = mem_rdata;
    end

    if ((state_q == ACK) && !req_s && ((op_q == OP_WR) || (op_q == OP_RD))) begin
      addr_d = addr_q + ADDR_W'(1);
    end

    mem_we_d = (state_d == EXEC) && (op_d == OP_WR);
    mem_re_d = (state_d == EXEC) && (op_d == OP_RD);
    ack_d    = (state_d == ACK);
    busy_d   = (state_d != IDLE);
    uio_oe_d = ((state_d == ACK) && (op_d == OP_RD)) ? 8'hFF : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q      <= OP_NOP;
      data_q    <= 8'h00;
      addr_q    <= '0;
      uio_out_q <= 8'h00;
      uio_oe_q  <= 8'h00;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_re_q  <= 1'b0;
    end else begin
      op_q      <= op_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      uio_out_q <= uio_out_d;
      uio_oe_q  <= uio_oe_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      mem_we_q  <= mem_we_d;
      mem_re_q  <= mem_re_d;
    end
  end

  assign ack       = ack_q;
  assign busy      = busy_q;
  assign uio_out   = uio_out_q;
  assign uio_oe    = uio_oe_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = data_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;

endmodule
